// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
// Optional frame counter in vga_timing_fsm is enabled with VGA_FRAME_CNT_EN.
package vga_pkg;

  typedef enum logic {S_IDLE, S_RUN} top_state_t;
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: ACT->FP->SYNC->BP phase FSM with a per-phase length counter.
// Advances on step_i; wrap_o marks the step that leaves the last BP count.
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int LEN_ACT  = 640,
  parameter int LEN_FP   = 16,
  parameter int LEN_SYNC = 96,
  parameter int LEN_BP   = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_i,
  output phase_t           phase_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;
  logic             at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= ACT;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    last_cnt = CNT_W'(LEN_ACT - 1);
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    unique case (phase_q)
      ACT:  last_cnt = CNT_W'(LEN_ACT - 1);
      FP:   last_cnt = CNT_W'(LEN_FP - 1);
      SYNC: last_cnt = CNT_W'(LEN_SYNC - 1);
      BP:   last_cnt = CNT_W'(LEN_BP - 1);
    endcase
    at_last = (cnt_q == last_cnt);
    if (step_i) begin
      if (at_last) begin
        cnt_d = '0;
        unique case (phase_q)
          ACT:  phase_d = FP;
          FP:   phase_d = SYNC;
          SYNC: phase_d = BP;
          BP:   phase_d = ACT;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign phase_o = phase_q;
  assign cnt_o   = cnt_q;
  assign wrap_o  = step_i && (phase_q == BP) && at_last;

endmodule

// File: rtl/vga_timing_fsm.sv
// VGA raster timing generator: run/stop control over chained H and V axis FSMs.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_fsm
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             run,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_start,
  output logic             busy
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_len
    $error("vga_timing_fsm: every timing length must be at least 1");
  end
  if (max4(max4(H_ACTIVE, H_FP, H_SYNC, H_BP), V_ACTIVE, max4(V_FP, V_SYNC, V_BP, 1), 1) - 1
      >= (1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_fsm: CNT_W too narrow for the timing lengths");
  end

  top_state_t       state_q, state_d;
  phase_t           hphase, vphase;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic             running, hstep, hwrap, vwrap, frame_wrap;

  assign running    = (state_q == S_RUN);
  assign hstep      = running && pix_en;
  assign frame_wrap = hwrap && vwrap;

  vga_axis_fsm #(
    .CNT_W(CNT_W), .LEN_ACT(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP)
  ) u_haxis (
    .clk(clk), .reset(reset), .step_i(hstep),
    .phase_o(hphase), .cnt_o(hcnt), .wrap_o(hwrap)
  );

  // The vertical axis advances once per completed line.
  vga_axis_fsm #(
    .CNT_W(CNT_W), .LEN_ACT(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP)
  ) u_vaxis (
    .clk(clk), .reset(reset), .step_i(hwrap),
    .phase_o(vphase), .cnt_o(vcnt), .wrap_o(vwrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Dropping run only takes effect at the frame boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_RUN;
      S_RUN:  if (frame_wrap && !run) state_d = S_IDLE;
    endcase
  end

  assign hsync       = (running && hphase == SYNC) ? HS_POL : !HS_POL;
  assign vsync       = (running && vphase == SYNC) ? VS_POL : !VS_POL;
  assign video_on    = running && (hphase == ACT) && (vphase == ACT);
  assign x           = video_on ? hcnt : '0;
  assign y           = video_on ? vcnt : '0;
  assign line_end    = hwrap;
  assign frame_start = hstep && (hphase == ACT) && (vphase == ACT) &&
                       (hcnt == '0) && (vcnt == '0);
  assign busy        = running;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_fsm.sv
// Bench for vga_timing_fsm: a small-timing instance and a default 640x480 instance.
// Honours VGA_FRAME_CNT_EN when the design is built with the frame counter.
module tb_vga_timing_fsm;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vid;
    logic       le;
    logic       fs;
    logic       bsy;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  typedef struct {
    bit   pixEn;
    bit   runIn;
    obs_t want;
  } vec_t;

  localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVA = 2, SVF = 1, SVS = 1, SVB = 1;
  localparam int FRAME_S = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
  localparam int FRAME_B = 800 * 525;

  logic       clk = 1'b0;
  logic       rstS = 1'b0, pixS = 1'b0, runS = 1'b0;
  logic       rstB = 1'b0, pixB = 1'b0, runB = 1'b0;
  logic       hsyncS, vsyncS, videoS, leS, fsS, busyS;
  logic       hsyncB, vsyncB, videoB, leB, fsB, busyB;
  logic [9:0] xS, yS, xB, yB;
  obs_t       obsS, obsB;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frameCntS, frameCntB;
`endif

  int checks = 0;
  int failures = 0;

  bit runningS, runningB;
  int tS, tB;

  always #5 clk = ~clk;

  vga_timing_fsm #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(10)
  ) dutSmall (
    .clk(clk), .reset(rstS), .pix_en(pixS), .run(runS),
    .hsync(hsyncS), .vsync(vsyncS), .video_on(videoS), .x(xS), .y(yS),
    .line_end(leS), .frame_start(fsS), .busy(busyS)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frameCntS)
`endif
  );

  vga_timing_fsm dutBig (
    .clk(clk), .reset(rstB), .pix_en(pixB), .run(runB),
    .hsync(hsyncB), .vsync(vsyncB), .video_on(videoB), .x(xB), .y(yB),
    .line_end(leB), .frame_start(fsB), .busy(busyB)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frameCntB)
`endif
  );

  assign obsS = {hsyncS, vsyncS, videoS, leS, fsS, busyS, xS, yS};
  assign obsB = {hsyncB, vsyncB, videoB, leB, fsB, busyB, xB, yB};

  function automatic obs_t mkObs(input bit hs, input bit vs, input bit vid, input bit le,
                                 input bit fs, input bit bsy, input int xv, input int yv);
    obs_t o;
    o.hs = hs; o.vs = vs; o.vid = vid; o.le = le; o.fs = fs; o.bsy = bsy;
    o.x = 10'(xv); o.y = 10'(yv);
    return o;
  endfunction

  // Expected outputs from the tick position within the frame (active-low syncs).
  function automatic obs_t refModel(input int ha, input int hf, input int hs, input int hb,
                                    input int va, input int vf, input int vs,
                                    input bit running, input int t, input bit p);
    int lineLen;
    int hpos;
    int vline;
    bit vid;
    lineLen = ha + hf + hs + hb;
    hpos    = t % lineLen;
    vline   = t / lineLen;
    vid     = running && hpos < ha && vline < va;
    return mkObs(!(running && hpos >= ha + hf && hpos < ha + hf + hs),
                 !(running && vline >= va + vf && vline < va + vf + vs),
                 vid, running && p && hpos == lineLen - 1,
                 running && p && t == 0, running,
                 vid ? hpos : 0, vid ? vline : 0);
  endfunction

  task automatic modelStep(input int frameLen, input bit p, input bit r,
                           inout bit running, inout int t);
    if (!running) begin
      if (r) running = 1'b1;
    end else if (p) begin
      t++;
      if (t == frameLen) begin
        t = 0;
        if (!r) running = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got hs/vs/vid/le/fs/busy=%b%b%b%b%b%b x=%0d y=%0d, want %b%b%b%b%b%b x=%0d y=%0d",
               name, act.hs, act.vs, act.vid, act.le, act.fs, act.bsy, act.x, act.y,
               want.hs, want.vs, want.vid, want.le, want.fs, want.bsy, want.x, want.y);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic applyStimulus(input bit big, input bit p, input bit r);
    @(negedge clk);
    if (big) begin pixB = p; runB = r; end
    else     begin pixS = p; runS = r; end
    #1;
  endtask

  task automatic resetSmall();
    @(negedge clk);
    rstS = 1'b0; pixS = 1'b0; runS = 1'b0;
    #1;
    checkOutput("resetSmall", obsS, mkObs(1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rstS = 1'b1;
    runningS = 1'b0;
    tS = 0;
  endtask

  vec_t vecs[14];

  initial begin
    bit   p, r;
    int   n;
    int   leCount, firstLe, secondLe, hsLow, firstHsLow;

    $display("[TB] start");
    #12;
    checkOutput("resetBig", obsB, mkObs(1, 1, 0, 0, 0, 0, 0, 0));

    // Golden sequence on the small timing with pix_en mostly every other clock.
    vecs[0]  = '{1, 1, mkObs(1, 1, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1, 1, mkObs(1, 1, 1, 0, 1, 1, 0, 0)};
    vecs[2]  = '{0, 1, mkObs(1, 1, 1, 0, 0, 1, 1, 0)};
    vecs[3]  = '{1, 1, mkObs(1, 1, 1, 0, 0, 1, 1, 0)};
    vecs[4]  = '{0, 1, mkObs(1, 1, 1, 0, 0, 1, 2, 0)};
    vecs[5]  = '{1, 1, mkObs(1, 1, 1, 0, 0, 1, 2, 0)};
    vecs[6]  = '{1, 1, mkObs(1, 1, 1, 0, 0, 1, 3, 0)};
    vecs[7]  = '{1, 1, mkObs(1, 1, 0, 0, 0, 1, 0, 0)};
    vecs[8]  = '{1, 1, mkObs(0, 1, 0, 0, 0, 1, 0, 0)};
    vecs[9]  = '{0, 1, mkObs(0, 1, 0, 0, 0, 1, 0, 0)};
    vecs[10] = '{1, 1, mkObs(0, 1, 0, 0, 0, 1, 0, 0)};
    vecs[11] = '{1, 1, mkObs(1, 1, 0, 1, 0, 1, 0, 0)};
    vecs[12] = '{0, 1, mkObs(1, 1, 1, 0, 0, 1, 0, 1)};
    vecs[13] = '{1, 1, mkObs(1, 1, 1, 0, 0, 1, 0, 1)};

    resetSmall();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, vecs[i].pixEn, vecs[i].runIn);
      checkOutput($sformatf("table[%0d]", i), obsS, vecs[i].want);
    end

    // Random pix_en/run against the tick-position model.
    resetSmall();
    for (int i = 0; i < 3000; i++) begin
      p = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) < 85);
      applyStimulus(1'b0, p, r);
      checkOutput("randSmall", obsS,
                  refModel(SHA, SHF, SHS, SHB, SVA, SVF, SVS, runningS, tS, p));
      modelStep(FRAME_S, p, r, runningS, tS);
    end

    // Drop run in line 2: the frame must still complete before IDLE.
    resetSmall();
    applyStimulus(1'b0, 1, 1);
    modelStep(FRAME_S, 1, 1, runningS, tS);
    while (tS < 17) begin
      applyStimulus(1'b0, 1, 1);
      modelStep(FRAME_S, 1, 1, runningS, tS);
    end
    n = 0;
    do begin
      applyStimulus(1'b0, 1, 0);
      if (!busyS) break;
      n++;
    end while (n < 100);
    checkVal("runDropTicks", n, FRAME_S - 17);
    checkOutput("idleAfterDrop", obsS, mkObs(1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1, 1);
    applyStimulus(1'b0, 1, 1);
    checkOutput("restartFrameStart", obsS, mkObs(1, 1, 1, 0, 1, 1, 0, 0));

`ifdef VGA_FRAME_CNT_EN
    resetSmall();
    checkVal("frameCntReset", int'(frameCntS), 0);
    applyStimulus(1'b0, 1, 1);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1, 1);
    checkVal("frameCntTwo", int'(frameCntS), 2);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1, 0);
    checkVal("frameCntThree", int'(frameCntS), 3);
    checkVal("frameCntIdle", int'(busyS), 0);
    checkVal("frameCntBigReset", int'(frameCntB), 0);
`endif

    // Default 640x480 timing, pix_en tied high, two lines plus part of a third.
    @(negedge clk);
    rstB = 1'b1;
    runningB = 1'b0;
    tB = 0;
    leCount = 0; firstLe = -1; secondLe = -1; hsLow = 0; firstHsLow = -1;
    applyStimulus(1'b1, 1, 1);
    checkOutput("bigIdleFirst", obsB, mkObs(1, 1, 0, 0, 0, 0, 0, 0));
    modelStep(FRAME_B, 1, 1, runningB, tB);
    while (tB < 1900) begin
      applyStimulus(1'b1, 1, 1);
      checkOutput("bigRaster", obsB,
                  refModel(640, 16, 96, 48, 480, 10, 2, runningB, tB, 1'b1));
      if (obsB.le) begin
        leCount++;
        if (firstLe < 0) firstLe = tB;
        else if (secondLe < 0) secondLe = tB;
      end
      if (tB < 800 && !obsB.hs) begin
        hsLow++;
        if (firstHsLow < 0) firstHsLow = tB;
      end
      modelStep(FRAME_B, 1, 1, runningB, tB);
    end
    checkVal("lineEndCount", leCount, 2);
    checkVal("firstLineEnd", firstLe, 799);
    checkVal("secondLineEnd", secondLe, 1599);
    checkVal("hsyncLowWidth", hsLow, 96);
    checkVal("hsyncLowStart", firstHsLow, 656);

    // Asynchronous reset mid-line at hcnt=300, checked before any clock edge.
    applyStimulus(1'b1, 1, 1);
    checkVal("xBeforeReset", int'(xB), 300);
    #2;
    rstB = 1'b0;
    #1;
    checkOutput("asyncResetMidLine", obsB, mkObs(1, 1, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
